// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: accepts 9-bit instructions, reads the
// register file, holds ALU inputs for ALU_LAT cycles, then writes back and resolves branches.
module alu_issue_ctrl #(
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned NREGS   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [8:0] instr,
    output logic       instr_ready,
    output logic [5:0] alu_opcode,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    input  logic [7:0] alu_result,
    input  logic       alu_overflow,
    output logic       branch_taken,
    output logic [2:0] branch_offset,
    output logic       instr_done,
    output logic       flag,
    output logic       halted,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB, HALTED} state_t;

    localparam int unsigned CW = $clog2(ALU_LAT + 1);

    state_t     state;
    logic [8:0] ir;
    logic [CW-1:0] cnt;
    logic [7:0] regs [NREGS];

    // issue-side decode of the incoming word
    logic       iss_alu;
    logic       iss_zero_in1;
    logic [5:0] iss_opcode;
    logic       iss_take;

    // writeback-side decode of the registered word
    logic       wb_mov;
    logic       wb_wr_reg;
    logic       wb_wr_flag;
    logic       wb_halt;
    logic [2:0] wb_dst;

    assign instr_ready = (state == IDLE);
    assign dbg_data    = regs[dbg_addr];

    always_comb begin
        iss_alu      = 1'b0;
        iss_zero_in1 = 1'b0;
        iss_opcode   = '0;
        iss_take     = 1'b0;
        case (instr[8:6])
            3'b010, 3'b011, 3'b100, 3'b101: begin
                iss_alu    = 1'b1;
                iss_opcode = {instr[8:6], 3'b000};
            end
            3'b110: begin
                // funcs 110 (NOP) and 111 (HALT) never reach the ALU
                if (instr[5:4] != 2'b11) begin
                    iss_alu      = 1'b1;
                    iss_zero_in1 = 1'b1;
                    iss_opcode   = instr[8:3];
                end
            end
            3'b111: begin
                iss_take = ((instr[5:3] == 3'b000) && !flag) ||
                           ((instr[5:3] == 3'b001) && flag);
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_mov     = (ir[8:6] == 3'b000);
        wb_dst     = (ir[8:6] == 3'b110) ? ir[2:0] : ir[5:3];
        wb_wr_reg  = 1'b0;
        wb_wr_flag = 1'b0;
        wb_halt    = (ir[8:3] == 6'b110111);
        case (ir[8:6])
            3'b010: begin
                wb_wr_reg  = 1'b1;
                wb_wr_flag = 1'b1;
            end
            3'b011, 3'b100: wb_wr_flag = 1'b1;
            3'b101:         wb_wr_reg  = 1'b1;
            3'b110: begin
                wb_wr_reg  = (ir[5] == 1'b0);
                wb_wr_flag = (ir[5:3] == 3'b000) || (ir[5:3] == 3'b100) ||
                             (ir[5:3] == 3'b101);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ir            <= '0;
            cnt           <= '0;
            alu_opcode    <= '0;
            alu_in1       <= '0;
            alu_in2       <= '0;
            branch_taken  <= 1'b0;
            branch_offset <= '0;
            instr_done    <= 1'b0;
            halted        <= 1'b0;
            flag          <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            instr_done    <= 1'b0;
            branch_taken  <= 1'b0;
            branch_offset <= '0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir  <= instr;
                        cnt <= '0;
                        if (iss_alu) begin
                            state      <= EXEC;
                            alu_opcode <= iss_opcode;
                            alu_in1    <= iss_zero_in1 ? '0 : regs[instr[5:3]];
                            alu_in2    <= regs[instr[2:0]];
                        end else begin
                            state         <= WB;
                            instr_done    <= 1'b1;
                            branch_taken  <= iss_take;
                            branch_offset <= iss_take ? instr[2:0] : '0;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == CW'(ALU_LAT - 1)) begin
                        state      <= WB;
                        instr_done <= 1'b1;
                        alu_opcode <= '0;
                        alu_in1    <= '0;
                        alu_in2    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WB: begin
                    // the ALU holds its output while idle, so sampling here is safe
                    if (wb_mov) begin
                        regs[wb_dst] <= regs[ir[2:0]];
                    end else if (wb_wr_reg) begin
                        regs[wb_dst] <= alu_result;
                    end
                    if (wb_wr_flag) begin
                        flag <= alu_overflow;
                    end
                    if (wb_halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: models the external ALU and an ISA-level
// reference of the register file, flag, branch and halt behaviour.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    localparam int unsigned ALU_LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic [5:0] alu_opcode;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [7:0] alu_result;
    logic       alu_overflow;
    logic       branch_taken;
    logic [2:0] branch_offset;
    logic       instr_done;
    logic       flag;
    logic       halted;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [7:0] mreg [8];
    logic       mflag;

    alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .NREGS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .alu_opcode   (alu_opcode),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .instr_done   (instr_done),
        .flag         (flag),
        .halted       (halted),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #20 clk = ~clk;

    // Behavioural ALU: returns {overflow, result}
    function automatic logic [8:0] alu_fn(input logic [5:0] opc, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] s;
        case (opc)
            6'b010000: s = {1'b0, x} + {1'b0, y};
            6'b011000: s = {x == y, x ^ y};
            6'b100000: s = {$signed(x) < $signed(y), 8'(x + 8'd1)};
            6'b101000: s = {x < y, (x > y) ? 8'(x - y) : 8'(y - x)};
            6'b110000: s = {y[7], y[6:0], 1'b0};
            6'b110001: s = {y[0], 1'b0, y[7:1]};
            6'b110010: s = {y == 8'hff, 8'(y + 8'd1)};
            6'b110011: s = {1'b1, 8'h00};
            6'b110100: s = {y[0], ~y};
            6'b110101: s = {y == 8'h00, y ^ 8'h5a};
            default:   s = 9'h000;
        endcase
        return s;
    endfunction

    // ALU with two pipeline stages that hold while opcode is idle
    logic [8:0] s1 = '0, s2 = '0;
    always @(posedge clk) begin
        if (alu_opcode != 6'b000000) begin
            s1 <= alu_fn(alu_opcode, alu_in1, alu_in2);
            s2 <= s1;
        end
    end
    assign alu_result   = s2[7:0];
    assign alu_overflow = s2[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [7:0] v);
        dbg_addr = idx;
        #1;
        v = dbg_data;
    endtask

    task automatic check_regs(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            check($sformatf("%s_r%0d", tag, i), v, mreg[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        mflag = 1'b0;
    endtask

    // ISA-level effect of one instruction on the reference state
    task automatic model(input logic [8:0] w, output bit uses, output logic [5:0] opc,
                         output logic [7:0] i1, output logic [7:0] i2,
                         output bit take, output logic [2:0] off, output bit halt);
        logic [2:0] op, a, b;
        logic [8:0] r;
        op = w[8:6]; a = w[5:3]; b = w[2:0];
        uses = 0; opc = '0; i1 = '0; i2 = '0; take = 0; off = '0; halt = 0;
        case (op)
            3'd0: mreg[a] = mreg[b];
            3'd2, 3'd3, 3'd4, 3'd5: begin
                uses = 1; opc = {op, 3'b000}; i1 = mreg[a]; i2 = mreg[b];
                r = alu_fn(opc, i1, i2);
                if (op == 3'd2) begin mreg[a] = r[7:0]; mflag = r[8]; end
                if (op == 3'd3 || op == 3'd4) mflag = r[8];
                if (op == 3'd5) mreg[a] = r[7:0];
            end
            3'd6: begin
                if (a == 3'd7) halt = 1;
                else if (a != 3'd6) begin
                    uses = 1; opc = {op, a}; i1 = 8'h00; i2 = mreg[b];
                    r = alu_fn(opc, i1, i2);
                    if (a <= 3'd3) mreg[b] = r[7:0];
                    if (a == 3'd0 || a == 3'd4 || a == 3'd5) mflag = r[8];
                end
            end
            3'd7: begin
                take = (a == 3'd0 && !mflag) || (a == 3'd1 && mflag);
                off  = take ? b : 3'b000;
            end
            default: ;
        endcase
    endtask

    // Drive one instruction from a negedge and check every cycle until it retires
    task automatic issue(input logic [8:0] w);
        bit uses, take, halt;
        logic [5:0] opc;
        logic [7:0] i1, i2, old_dst, v;
        logic [2:0] off, dst;
        dst     = (w[8:6] == 3'b110) ? w[2:0] : w[5:3];
        old_dst = mreg[dst];
        model(w, uses, opc, i1, i2, take, off, halt);
        check("ready_idle", instr_ready, 1);
        instr = w; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = 9'($urandom);
        if (uses) begin
            for (int k = 0; k < ALU_LAT; k++) begin
                @(negedge clk);
                check("exec_opcode", alu_opcode, opc);
                check("exec_in1", alu_in1, i1);
                check("exec_in2", alu_in2, i2);
                check("exec_done", instr_done, 0);
                check("exec_ready", instr_ready, 0);
            end
        end
        @(negedge clk);
        check("wb_done", instr_done, 1);
        check("wb_ready", instr_ready, 0);
        check("wb_opcode", alu_opcode, 0);
        check("wb_branch", branch_taken, take);
        check("wb_offset", branch_offset, off);
        read_reg(dst, v);
        check("wb_old_value", v, old_dst);
        @(negedge clk);
        check("post_done", instr_done, 0);
        check("post_branch", branch_taken, 0);
        check("post_opcode", alu_opcode, 0);
        check("post_halted", halted, halt);
        check("post_ready", instr_ready, !halt);
        check("post_flag", flag, mflag);
        check_regs("post");
    endtask

    task automatic load(input logic [2:0] r, input logic [7:0] val);
        issue({3'b110, 3'b011, r});
        for (int i = 7; i >= 0; i--) begin
            issue({3'b110, 3'b000, r});
            if (val[i]) issue({3'b110, 3'b010, r});
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [8:0] w;
        reset = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_opcode", alu_opcode, 0);
        check("rst_in1", alu_in1, 0);
        check("rst_in2", alu_in2, 0);
        check("rst_done", instr_done, 0);
        check("rst_branch", branch_taken, 0);
        check("rst_halted", halted, 0);
        check("rst_flag", flag, 0);
        reset = 1'b0;
        check_regs("rst");

        // ZERO r1, 3x INCR r1
        issue(9'b110_011_001);
        repeat (3) issue(9'b110_010_001);
        read_reg(3'd1, v); check("incr_r1", v, 8'd3);
        check("incr_flag", flag, 0);

        // ADD with carry, then BOF taken
        load(3'd1, 8'd200);
        load(3'd2, 8'd100);
        issue(9'b010_001_010);
        read_reg(3'd1, v); check("add_r1", v, 8'd44);
        check("add_flag", flag, 1);
        issue(9'b111_001_101);

        // signed LT false, BNO taken, BOF not taken
        load(3'd1, 8'd3);
        load(3'd2, 8'hfe);
        issue(9'b100_001_010);
        check("lt_flag", flag, 0);
        read_reg(3'd1, v); check("lt_r1", v, 8'd3);
        issue(9'b111_000_010);
        issue(9'b111_001_011);

        // DIST then MOV
        load(3'd3, 8'd5);
        load(3'd4, 8'd12);
        issue(9'b101_011_100);
        read_reg(3'd3, v); check("dist_r3", v, 8'd7);
        issue(9'b000_101_011);
        read_reg(3'd5, v); check("mov_r5", v, 8'd7);

        // randomized instruction stream (HALT replaced by NOP)
        for (int n = 0; n < 300; n++) begin
            w = 9'($urandom);
            if (w[8:3] == 6'b110111) w[8:6] = 3'b001;
            issue(w);
        end

        // reset during second EXEC cycle of INCR r1
        load(3'd1, 8'd9);
        instr = 9'b110_010_001; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("abort_exec1", alu_opcode, 6'b110010);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_done", instr_done, 0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort_ready", instr_ready, 1);
        check("abort_done", instr_done, 0);
        read_reg(3'd1, v); check("abort_r1", v, 8'd0);
        check_regs("abort");

        // HALT, then ignored requests, then reset
        load(3'd6, 8'd21);
        issue(9'b110_111_000);
        instr = 9'b110_010_110; instr_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("halt_ready", instr_ready, 0);
            check("halt_done", instr_done, 0);
            check("halt_halted", halted, 1);
            check("halt_opcode", alu_opcode, 0);
        end
        instr_valid = 1'b0;
        check_regs("halt");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("unhalt_halted", halted, 0);
        check("unhalt_ready", instr_ready, 1);
        check_regs("unhalt");
        issue(9'b110_010_000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
